// File: rtl/proc_pkg.sv
// Shared types and constants for the 16-bit core sequencer.
// Holds the FSM state encoding, the opcode field position and the default HALT opcode.
// No logic; pure declarations.
package proc_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcode lives in IR[15:12]
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] HALT_OPC_DEFAULT = 4'hF;

endpackage

// File: rtl/pc_counter.sv
// Program counter: 16-bit register with branch load and increment.
// Latency: pc updates on the edge after load/inc; pc_nxt is the combinational next value.
// No backpressure; load takes priority over increment.
module pc_counter #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] load_val,
  output logic [15:0] pc,
  output logic [15:0] pc_nxt
);

  // Next-PC selection: branch target beats sequential increment; wraps at 16 bits
  always_comb begin
    pc_nxt = pc;
    if (load)
      pc_nxt = load_val;
    else if (inc)
      pc_nxt = pc + 16'd1;
  end

  // PC register with asynchronous clear to the boot address
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      pc <= RESET_PC;
    else
      pc <= pc_nxt;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencer: owns the PC, runs the imem req/ack handshake, starts execute.
// Latency: 3 cycles per instruction minimum (FETCH, DECODE, EXEC); mem_req 1 cycle after run.
// Backpressure: FETCH holds mem_req until mem_ack; EXEC waits for exec_done. Optional
// fetch timeout enabled by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl
  import proc_pkg::*;
#(
  parameter logic [15:0]      RESET_PC       = 16'h0000,
  parameter logic [OPC_W-1:0] HALT_OPCODE    = HALT_OPC_DEFAULT,
  parameter int               TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  output logic             en_ir,
  input  logic [OPC_W-1:0] ir_opcode,
  output logic             exec_start,
  input  logic             exec_done,
  input  logic             br_taken,
  input  logic [15:0]      br_target,
  output logic             halted,
  output logic             fault
);

  // Timeout limit must fit the 8-bit wait counter
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES out of range 1..255");
  end

  state_t      state;
  logic        accept;
  logic [15:0] pc;
  logic [15:0] pc_nxt;

  // exec_done only counts while executing; it drives the PC update
  assign accept = (state == ST_EXEC) && exec_done;

  // IR captures the fetched word in the ack cycle
  assign en_ir = (state == ST_FETCH) && mem_ack;

  pc_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .clr      (clr),
    .load     (accept && br_taken),
    .inc      (accept && !br_taken),
    .load_val (br_target),
    .pc       (pc),
    .pc_nxt   (pc_nxt)
  );

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tcnt;
`else
  assign fault = 1'b0;
`endif

  // Sequencer FSM with registered handshake outputs. mem_addr follows pc_nxt so the
  // updated PC is presented on the same edge that mem_req rises.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ST_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      exec_start <= 1'b0;
      halted     <= 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
      tcnt       <= 8'd0;
      fault      <= 1'b0;
`endif
    end else begin
      mem_addr   <= pc_nxt;
      exec_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
`ifdef FETCH_CTRL_TIMEOUT_EN
            tcnt    <= 8'd0;
`endif
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            state   <= ST_DECODE;
            mem_req <= 1'b0;
          end
`ifdef FETCH_CTRL_TIMEOUT_EN
          // An ack in the limit cycle wins over the timeout
          else if (tcnt == TO_LIMIT) begin
            state   <= ST_HALT;
            mem_req <= 1'b0;
            halted  <= 1'b1;
            fault   <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end
        ST_DECODE: begin
          if (ir_opcode == HALT_OPCODE) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state      <= ST_EXEC;
            exec_start <= 1'b1;
          end
        end
        ST_EXEC: begin
          // A dropped run lets the current instruction finish, then parks in IDLE
          if (exec_done) begin
            if (run) begin
              state   <= ST_FETCH;
              mem_req <= 1'b1;
`ifdef FETCH_CTRL_TIMEOUT_EN
              tcnt    <= 8'd0;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HALT: begin
          // Only clr leaves HALT
          mem_req <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
